// File: rtl/eeprom_save_arbiter.sv
// Arbitrates the single-port save BRAM between the never-stallable EEPROM core
// and the host save/load handshake port; tracks dirty and strobe-collision errors.
module eeprom_save_arbiter #(
   parameter int AW = 13,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] ee_addr,
   input  logic [DW-1:0] ee_d,
   input  logic          ee_wr,
   input  logic          ee_rd,
   output logic [DW-1:0] ee_q,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_din,
   output logic [DW-1:0] host_dout,
   output logic          host_ack,
   input  logic          host_load,
   input  logic          clr_dirty,
   output logic          dirty,
   output logic          err,
   output logic [AW-1:0] bram_addr,
   output logic [DW-1:0] bram_d,
   output logic          bram_we,
   input  logic [DW-1:0] bram_q
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_WAIT = 2'd1;
   localparam logic [1:0] ACK     = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] host_dout_q, host_dout_d;
   logic [DW-1:0] ee_q_hold_q, ee_q_hold_d;
   logic          ee_rd_dly_q, ee_rd_dly_d;
   logic          dirty_q, dirty_d;
   logic          err_q, err_d;
   logic [AW-1:0] addr_hold_q, addr_hold_d;
   logic [DW-1:0] din_hold_q, din_hold_d;

   logic ee_slot;
   logic ee_wr_ok;
   logic grant;

   assign ee_slot  = ee_wr | ee_rd;
   assign ee_wr_ok = ee_wr & ~host_load;
   assign host_ack = (state_q == ACK);

   // Grant is suppressed while in reset so an aborted access cannot touch the BRAM.
   assign grant = (state_q == IDLE) & host_req & ~ee_slot & ~host_ack & ~rst;

   assign ee_q      = ee_rd_dly_q ? bram_q : ee_q_hold_q;
   assign host_dout = host_dout_q;
   assign dirty     = dirty_q;
   assign err       = err_q;

   always_comb begin
      bram_addr   = addr_hold_q;
      bram_d      = din_hold_q;
      bram_we     = 1'b0;
      addr_hold_d = addr_hold_q;
      din_hold_d  = din_hold_q;
      if (ee_slot) begin
         bram_addr   = ee_addr;
         bram_d      = ee_d;
         bram_we     = ee_wr_ok;
         addr_hold_d = ee_addr;
         din_hold_d  = ee_d;
      end else if (grant) begin
         bram_addr   = host_addr;
         bram_d      = host_din;
         bram_we     = host_we;
         addr_hold_d = host_addr;
         din_hold_d  = host_din;
      end
   end

   always_comb begin
      state_d     = state_q;
      host_dout_d = host_dout_q;
      case (state_q)
         IDLE: begin
            if (grant) begin
               state_d = host_we ? ACK : RD_WAIT;
            end
         end
         RD_WAIT: begin
            host_dout_d = bram_q;
            state_d     = ACK;
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A write+read collision performs the write only, so the read return is not armed.
   always_comb begin
      ee_rd_dly_d = ee_rd & ~ee_wr;
      ee_q_hold_d = ee_rd_dly_q ? bram_q : ee_q_hold_q;
      err_d       = err_q | (ee_wr & ee_rd);
      dirty_d     = dirty_q;
      if (ee_wr_ok) begin
         dirty_d = 1'b1;
      end else if (clr_dirty) begin
         dirty_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         host_dout_q <= '0;
         ee_q_hold_q <= '0;
         ee_rd_dly_q <= 1'b0;
         dirty_q     <= 1'b0;
         err_q       <= 1'b0;
         addr_hold_q <= '0;
         din_hold_q  <= '0;
      end else begin
         state_q     <= state_d;
         host_dout_q <= host_dout_d;
         ee_q_hold_q <= ee_q_hold_d;
         ee_rd_dly_q <= ee_rd_dly_d;
         dirty_q     <= dirty_d;
         err_q       <= err_d;
         addr_hold_q <= addr_hold_d;
         din_hold_q  <= din_hold_d;
      end
   end

endmodule

// File: tb/tb_eeprom_save_arbiter.sv
// Bench for eeprom_save_arbiter: directed scenarios followed by a randomized
// run checked against a transaction-level memory model.
module tb_eeprom_save_arbiter;

   localparam int AW = 13;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] ee_addr = '0;
   logic [DW-1:0] ee_d = '0;
   logic          ee_wr = 1'b0;
   logic          ee_rd = 1'b0;
   logic [DW-1:0] ee_q;
   logic          host_req = 1'b0;
   logic          host_we = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_din = '0;
   logic [DW-1:0] host_dout;
   logic          host_ack;
   logic          host_load = 1'b0;
   logic          clr_dirty = 1'b0;
   logic          dirty;
   logic          err;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_d;
   logic          bram_we;
   logic [DW-1:0] bram_q = '0;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [DW-1:0] mem     [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];

   eeprom_save_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .ee_addr(ee_addr), .ee_d(ee_d), .ee_wr(ee_wr), .ee_rd(ee_rd), .ee_q(ee_q),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_din(host_din), .host_dout(host_dout), .host_ack(host_ack),
      .host_load(host_load), .clr_dirty(clr_dirty), .dirty(dirty), .err(err),
      .bram_addr(bram_addr), .bram_d(bram_d), .bram_we(bram_we), .bram_q(bram_q)
   );

   always #5 clk = ~clk;

   // Single-port BRAM with registered read.
   always @(posedge clk) begin
      if (bram_we) mem[bram_addr] <= bram_d;
      bram_q <= mem[bram_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one host request and waits (bounded) for its ack; lat = -1 on timeout.
   task automatic host_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] din,
                              output logic [DW-1:0] dout, output int lat);
      lat  = -1;
      dout = '0;
      tick();
      host_req = 1'b1; host_we = we; host_addr = a; host_din = din;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (host_ack === 1'b1) begin
            lat  = i;
            dout = host_dout;
            break;
         end
         tick();
      end
      tick();
      host_req = 1'b0;
      $display("host %s addr=%h data=%h lat=%0d", we ? "wr" : "rd", a, we ? din : dout, lat);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      total_cnt++; if (host_ack !== 1'b0) $display("FAIL reset_ack got=%b exp=0", host_ack); else pass_cnt++;
      total_cnt++; if (host_dout !== 8'h00) $display("FAIL reset_dout got=%h exp=00", host_dout); else pass_cnt++;
      total_cnt++; if (ee_q !== 8'h00) $display("FAIL reset_eeq got=%h exp=00", ee_q); else pass_cnt++;
      total_cnt++; if ({dirty, err} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {dirty, err}); else pass_cnt++;
      total_cnt++; if (bram_we !== 1'b0) $display("FAIL reset_we got=%b exp=0", bram_we); else pass_cnt++;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_host_write_read();
      logic [DW-1:0] d;
      int lat;
      tick();
      host_req = 1'b1; host_we = 1'b1; host_addr = 13'h1A5; host_din = 8'h3C;
      @(negedge clk);
      total_cnt++; if ({bram_we, bram_addr, bram_d} !== {1'b1, 13'h1A5, 8'h3C})
         $display("FAIL hw_grant got=%b/%h/%h exp=1/1a5/3c", bram_we, bram_addr, bram_d); else pass_cnt++;
      total_cnt++; if (host_ack !== 1'b0) $display("FAIL hw_early_ack got=%b exp=0", host_ack); else pass_cnt++;
      tick();
      @(negedge clk);
      total_cnt++; if ({host_ack, bram_we} !== 2'b10) $display("FAIL hw_ack got=%b exp=10", {host_ack, bram_we}); else pass_cnt++;
      tick();
      host_req = 1'b0;
      @(negedge clk);
      total_cnt++; if (host_ack !== 1'b0) $display("FAIL hw_ack_len got=%b exp=0", host_ack); else pass_cnt++;
      total_cnt++; if (dirty !== 1'b0) $display("FAIL hw_no_dirty got=%b exp=0", dirty); else pass_cnt++;
      $display("host wr addr=1a5 data=3c lat=1");
      ref_mem[13'h1A5] = 8'h3C;
      host_access(1'b0, 13'h1A5, 8'h00, d, lat);
      total_cnt++; if (lat !== 2) $display("FAIL hr_lat got=%0d exp=2", lat); else pass_cnt++;
      total_cnt++; if (d !== 8'h3C) $display("FAIL hr_data got=%h exp=3c", d); else pass_cnt++;
   endtask

   task automatic test_ee_contention();
      int ack_cyc = -1;
      logic [DW-1:0] d = '0;
      tick();
      ee_wr = 1'b1; ee_addr = 13'h010; ee_d = 8'h55;
      host_req = 1'b1; host_we = 1'b0; host_addr = 13'h010;
      @(negedge clk);
      total_cnt++; if ({bram_we, bram_addr, bram_d} !== {1'b1, 13'h010, 8'h55})
         $display("FAIL ct_ee_first got=%b/%h/%h exp=1/010/55", bram_we, bram_addr, bram_d); else pass_cnt++;
      tick();
      ee_wr = 1'b0;
      @(negedge clk);
      total_cnt++; if ({bram_we, bram_addr} !== {1'b0, 13'h010})
         $display("FAIL ct_host_grant got=%b/%h exp=0/010", bram_we, bram_addr); else pass_cnt++;
      for (int i = 1; i < 10; i++) begin
         tick();
         @(negedge clk);
         if (host_ack === 1'b1) begin ack_cyc = i; d = host_dout; break; end
      end
      total_cnt++; if (ack_cyc !== 2) $display("FAIL ct_lat got=%0d exp=2", ack_cyc); else pass_cnt++;
      total_cnt++; if (d !== 8'h55) $display("FAIL ct_data got=%h exp=55", d); else pass_cnt++;
      total_cnt++; if (dirty !== 1'b1) $display("FAIL ct_dirty got=%b exp=1", dirty); else pass_cnt++;
      tick();
      host_req = 1'b0;
      $display("host rd addr=010 data=%h (after ee wr)", d);
   endtask

   task automatic test_ee_read();
      logic [DW-1:0] d;
      int lat;
      host_access(1'b1, 13'h020, 8'h99, d, lat);
      tick();
      ee_rd = 1'b1; ee_addr = 13'h020;
      tick();
      ee_rd = 1'b0;
      @(negedge clk);
      total_cnt++; if (ee_q !== 8'h99) $display("FAIL er_q got=%h exp=99", ee_q); else pass_cnt++;
      host_access(1'b1, 13'h020, 8'h11, d, lat);
      @(negedge clk);
      total_cnt++; if (ee_q !== 8'h99) $display("FAIL er_hold got=%h exp=99", ee_q); else pass_cnt++;
      tick();
      ee_rd = 1'b1;
      tick();
      ee_rd = 1'b0;
      @(negedge clk);
      total_cnt++; if (ee_q !== 8'h11) $display("FAIL er_q2 got=%h exp=11", ee_q); else pass_cnt++;
      $display("ee rd addr=020 data=%h", ee_q);
   endtask

   task automatic test_host_load();
      logic [DW-1:0] d;
      int lat;
      host_access(1'b1, 13'h030, 8'h42, d, lat);
      clr_dirty = 1'b1;
      tick();
      clr_dirty = 1'b0;
      @(negedge clk);
      total_cnt++; if (dirty !== 1'b0) $display("FAIL hl_clr got=%b exp=0", dirty); else pass_cnt++;
      tick();
      host_load = 1'b1; ee_wr = 1'b1; ee_addr = 13'h030; ee_d = 8'hFF;
      @(negedge clk);
      total_cnt++; if (bram_we !== 1'b0) $display("FAIL hl_we got=%b exp=0", bram_we); else pass_cnt++;
      tick();
      ee_wr = 1'b0; host_load = 1'b0;
      @(negedge clk);
      total_cnt++; if (dirty !== 1'b0) $display("FAIL hl_dirty got=%b exp=0", dirty); else pass_cnt++;
      host_access(1'b0, 13'h030, 8'h00, d, lat);
      total_cnt++; if (d !== 8'h42) $display("FAIL hl_mem got=%h exp=42", d); else pass_cnt++;
      ee_wr = 1'b1; ee_addr = 13'h030; ee_d = 8'hFF;
      @(negedge clk);
      total_cnt++; if (bram_we !== 1'b1) $display("FAIL hl_we2 got=%b exp=1", bram_we); else pass_cnt++;
      tick();
      ee_wr = 1'b0;
      @(negedge clk);
      total_cnt++; if (dirty !== 1'b1) $display("FAIL hl_dirty2 got=%b exp=1", dirty); else pass_cnt++;
      host_access(1'b0, 13'h030, 8'h00, d, lat);
      total_cnt++; if (d !== 8'hFF) $display("FAIL hl_mem2 got=%h exp=ff", d); else pass_cnt++;
   endtask

   task automatic test_dirty_err();
      logic [DW-1:0] d;
      int lat;
      clr_dirty = 1'b1; ee_wr = 1'b1; ee_addr = 13'h040; ee_d = 8'h77;
      tick();
      clr_dirty = 1'b0; ee_wr = 1'b0;
      @(negedge clk);
      total_cnt++; if (dirty !== 1'b1) $display("FAIL de_set_wins got=%b exp=1", dirty); else pass_cnt++;
      tick();
      clr_dirty = 1'b1;
      tick();
      clr_dirty = 1'b0;
      @(negedge clk);
      total_cnt++; if (dirty !== 1'b0) $display("FAIL de_clr got=%b exp=0", dirty); else pass_cnt++;
      total_cnt++; if (err !== 1'b0) $display("FAIL de_err0 got=%b exp=0", err); else pass_cnt++;
      tick();
      ee_wr = 1'b1; ee_rd = 1'b1; ee_addr = 13'h050; ee_d = 8'h66;
      @(negedge clk);
      total_cnt++; if ({bram_we, bram_addr} !== {1'b1, 13'h050}) $display("FAIL de_both_we got=%b/%h exp=1/050", bram_we, bram_addr); else pass_cnt++;
      tick();
      ee_wr = 1'b0; ee_rd = 1'b0;
      @(negedge clk);
      total_cnt++; if (err !== 1'b1) $display("FAIL de_err got=%b exp=1", err); else pass_cnt++;
      total_cnt++; if (ee_q !== 8'h11) $display("FAIL de_rd_ignored got=%h exp=11", ee_q); else pass_cnt++;
      host_access(1'b0, 13'h050, 8'h00, d, lat);
      total_cnt++; if (d !== 8'h66) $display("FAIL de_mem got=%h exp=66", d); else pass_cnt++;
      clr_dirty = 1'b1;
      tick();
      clr_dirty = 1'b0;
      @(negedge clk);
      total_cnt++; if (err !== 1'b1) $display("FAIL de_err_sticky got=%b exp=1", err); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int ack_cyc = -1;
      logic [DW-1:0] d = '0;
      tick();
      dirty_force_set();
      host_req = 1'b1; host_we = 1'b0; host_addr = 13'h1A5;
      @(negedge clk);
      total_cnt++; if ({bram_we, bram_addr} !== {1'b0, 13'h1A5}) $display("FAIL rm_grant got=%b/%h exp=0/1a5", bram_we, bram_addr); else pass_cnt++;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      total_cnt++; if (host_ack !== 1'b0) $display("FAIL rm_no_ack got=%b exp=0", host_ack); else pass_cnt++;
      total_cnt++; if ({dirty, err, ee_q, host_dout} !== 18'h0) $display("FAIL rm_outs got=%b%b/%h/%h exp=00/00/00", dirty, err, ee_q, host_dout); else pass_cnt++;
      total_cnt++; if ({bram_we, bram_addr} !== {1'b0, 13'h1A5}) $display("FAIL rm_regrant got=%b/%h exp=0/1a5", bram_we, bram_addr); else pass_cnt++;
      for (int i = 1; i < 10; i++) begin
         tick();
         @(negedge clk);
         if (host_ack === 1'b1) begin ack_cyc = i; d = host_dout; break; end
      end
      total_cnt++; if (ack_cyc !== 2) $display("FAIL rm_lat got=%0d exp=2", ack_cyc); else pass_cnt++;
      total_cnt++; if (d !== 8'h3C) $display("FAIL rm_data got=%h exp=3c", d); else pass_cnt++;
      tick();
      host_req = 1'b0;
      $display("host rd addr=1a5 data=%h (re-presented after reset)", d);
   endtask

   // Makes dirty set so the mid-transaction reset visibly clears it.
   task automatic dirty_force_set();
      ee_wr = 1'b1; ee_addr = 13'h060; ee_d = 8'h01;
      tick();
      ee_wr = 1'b0;
   endtask

   task automatic test_random();
      logic          pend = 1'b0;
      logic          h_we = 1'b0;
      logic [AW-1:0] h_addr = '0;
      logic [DW-1:0] h_din = '0;
      logic [DW-1:0] exp_dout = '0;
      logic [DW-1:0] exp_eeq = '0;
      logic          ack_we = 1'b0;
      logic          dirty_m = 1'b0;
      logic          err_m = 1'b0;
      logic          grant, exp_we;
      int            ack_at = -10;
      int            r;
      for (int c = 0; c < 600; c++) begin
         tick();
         if (!pend && $urandom_range(0, 2) == 0) begin
            pend   = 1'b1;
            h_we   = 1'($urandom_range(0, 1));
            h_addr = 13'h1000 + 13'($urandom_range(0, 31));
            h_din  = 8'($urandom);
         end
         host_req = pend; host_we = h_we; host_addr = h_addr; host_din = h_din;
         r = $urandom_range(0, 39);
         ee_wr = (r < 10) || (r == 39);
         ee_rd = (r >= 10 && r < 20) || (r == 39);
         ee_addr = 13'h1000 + 13'($urandom_range(0, 31));
         ee_d = 8'($urandom);
         host_load = ($urandom_range(0, 5) == 0);
         clr_dirty = ($urandom_range(0, 4) == 0);
         @(negedge clk);
         grant  = pend && !(ee_wr || ee_rd) && (c > ack_at);
         exp_we = (ee_wr || ee_rd) ? (ee_wr && !host_load) : (grant && h_we);
         total_cnt++; if (bram_we !== exp_we) $display("FAIL rnd_we c=%0d got=%b exp=%b", c, bram_we, exp_we); else pass_cnt++;
         total_cnt++; if (host_ack !== (c == ack_at)) $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, host_ack, c == ack_at); else pass_cnt++;
         if (c == ack_at) begin
            if (!ack_we) begin
               total_cnt++; if (host_dout !== exp_dout) $display("FAIL rnd_dout c=%0d got=%h exp=%h", c, host_dout, exp_dout); else pass_cnt++;
            end
            $display("rnd host %s addr=%h data=%h", ack_we ? "wr" : "rd", h_addr, ack_we ? h_din : exp_dout);
            pend = 1'b0;
         end
         total_cnt++; if (ee_q !== exp_eeq) $display("FAIL rnd_eeq c=%0d got=%h exp=%h", c, ee_q, exp_eeq); else pass_cnt++;
         total_cnt++; if (dirty !== dirty_m) $display("FAIL rnd_dirty c=%0d got=%b exp=%b", c, dirty, dirty_m); else pass_cnt++;
         total_cnt++; if (err !== err_m) $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err, err_m); else pass_cnt++;
         if (ee_rd && !ee_wr) exp_eeq = ref_mem[ee_addr];
         if (ee_wr && !host_load) ref_mem[ee_addr] = ee_d;
         if (grant) begin
            ack_at = c + (h_we ? 1 : 2);
            ack_we = h_we;
            if (h_we) ref_mem[h_addr] = h_din;
            else exp_dout = ref_mem[h_addr];
         end
         if (ee_wr && !host_load) dirty_m = 1'b1;
         else if (clr_dirty) dirty_m = 1'b0;
         if (ee_wr && ee_rd) err_m = 1'b1;
      end
      tick();
      host_req = 1'b0; ee_wr = 1'b0; ee_rd = 1'b0; host_load = 1'b0; clr_dirty = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i] = '0;
         ref_mem[i] = '0;
      end
      test_reset();
      test_host_write_read();
      test_ee_contention();
      test_ee_read();
      test_host_load();
      test_dirty_err();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
